bullet_damage_engine: RTL and testbench

- Parametrised successor to the single-bullet damage calculator; evaluates N bullet channels against the player per frame.
- Scans channels sequentially, one per cycle: AABB collision, then colour rule, then damage/heal accumulation.
- Applies the net result to a player HP register and runs an invulnerability window after damage.
- Sits between the bullet generators, the player module and the HUD/death logic.

---
 rtl/bullet_pkg.sv | 27 ++
 rtl/aabb_overlap.sv | 26 ++
 rtl/bullet_damage_engine.sv | 240 ++++++++++++++++++++++++
 tb/tb_bullet_damage_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bullet_pkg.sv
// Shared types and constants for the bullet damage engine: colour codes,
// coordinate widths, FSM state encoding and a saturating 8-bit adder.
package bullet_pkg;

    localparam int POS_W   = 16;
    localparam int COORD_W = 8;
    localparam int SIZE_W  = 8;
    localparam int COL_W   = 3;

    localparam logic [COL_W-1:0] COL_WHITE  = 3'd0;
    localparam logic [COL_W-1:0] COL_BLUE   = 3'd1;
    localparam logic [COL_W-1:0] COL_ORANGE = 3'd2;
    localparam logic [COL_W-1:0] COL_GREEN  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned square overlap test; edges that merely touch
// do not count as a hit.
module aabb_overlap
    import bullet_pkg::*;
(
    input  logic [COORD_W-1:0] i_ax,
    input  logic [COORD_W-1:0] i_ay,
    input  logic [SIZE_W-1:0]  i_asize,
    input  logic [COORD_W-1:0] i_bx,
    input  logic [COORD_W-1:0] i_by,
    input  logic [SIZE_W-1:0]  i_bsize,
    output logic               o_hit
);

    // One extra bit so far edges near 255 do not wrap.
    logic [COORD_W:0] w_ax_end, w_ay_end, w_bx_end, w_by_end;

    assign w_ax_end = {1'b0, i_ax} + {1'b0, i_asize};
    assign w_ay_end = {1'b0, i_ay} + {1'b0, i_asize};
    assign w_bx_end = {1'b0, i_bx} + {1'b0, i_bsize};
    assign w_by_end = {1'b0, i_by} + {1'b0, i_bsize};

    assign o_hit = ({1'b0, i_ax} < w_bx_end) && ({1'b0, i_bx} < w_ax_end) &&
                   ({1'b0, i_ay} < w_by_end) && ({1'b0, i_by} < w_ay_end);

endmodule

// File: rtl/bullet_damage_engine.sv
// Scans N bullet channels one per cycle, accumulates damage/heal and applies
// the net result to player HP. Optional hit statistics under DAMAGE_STATS_EN.
module bullet_damage_engine
    import bullet_pkg::*;
#(
    parameter int N_BULLET      = 4,
    parameter int DAMAGE        = 5,
    parameter int HEAL          = 3,
    parameter int MAX_HP        = 20,
    parameter int INVULN_CYCLES = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      is_move,
    input  logic                      load_hp,
    input  logic [7:0]                hp_init,
    input  logic [POS_W-1:0]          player_pos,
    input  logic [SIZE_W-1:0]         player_size,
    input  logic [POS_W*N_BULLET-1:0] bullet_pos,
    input  logic [SIZE_W*N_BULLET-1:0] bullet_size,
    input  logic [COL_W*N_BULLET-1:0] bullet_color,
    input  logic [N_BULLET-1:0]       bullet_render,
`ifdef DAMAGE_STATS_EN
    input  logic                      clr_stats,
    output logic [15:0]               hit_count,
`endif
    output logic [7:0]                hp,
    output logic                      is_dead,
    output logic                      busy,
    output logic                      done,
    output logic                      invuln,
    output logic [N_BULLET-1:0]       hit_mask,
    output logic [7:0]                dmg_total,
    output logic [7:0]                heal_total
);

    localparam int IDX_W = 4;
    localparam logic [IDX_W-1:0] LP_LAST_IDX = IDX_W'(N_BULLET - 1);
    localparam logic [7:0]  LP_MAX_HP = 8'(MAX_HP);
    localparam logic [7:0]  LP_DAMAGE = 8'(DAMAGE);
    localparam logic [7:0]  LP_HEAL   = 8'(HEAL);
    localparam logic [15:0] LP_INVULN = 16'(INVULN_CYCLES);

    state_t                r_state, w_state_next;
    logic [IDX_W-1:0]      r_idx;
    logic [7:0]            r_hp, r_dmg_acc, r_heal_acc, r_dmg_total, r_heal_total;
    logic [N_BULLET-1:0]   r_hit_work, r_hit_mask;
    logic                  r_move, r_done;
    logic [15:0]           r_inv_cnt;

    logic [COORD_W-1:0]    w_bx [N_BULLET];
    logic [COORD_W-1:0]    w_by [N_BULLET];
    logic [SIZE_W-1:0]     w_bsize [N_BULLET];
    logic [COL_W-1:0]      w_bcol [N_BULLET];

    logic [COORD_W-1:0]    w_sel_x, w_sel_y;
    logic [SIZE_W-1:0]     w_sel_size;
    logic [COL_W-1:0]      w_sel_col;
    logic                  w_sel_render;
    logic [N_BULLET-1:0]   w_sel_onehot;
    logic                  w_overlap, w_hit, w_dmg_hit, w_heal_hit;
    logic                  w_invuln, w_start_ok, w_load_ok;
    logic [7:0]            w_load_val, w_dmg_apply, w_hp_apply;
    logic signed [9:0]     w_hp_sum;

    for (genvar gi = 0; gi < N_BULLET; gi++) begin : g_unpack
        assign w_bx[gi]    = bullet_pos[POS_W*gi+8 +: 8];
        assign w_by[gi]    = bullet_pos[POS_W*gi +: 8];
        assign w_bsize[gi] = bullet_size[SIZE_W*gi +: SIZE_W];
        assign w_bcol[gi]  = bullet_color[COL_W*gi +: COL_W];
    end

    always_comb begin
        w_sel_x      = '0;
        w_sel_y      = '0;
        w_sel_size   = '0;
        w_sel_col    = '0;
        w_sel_render = 1'b0;
        w_sel_onehot = '0;
        for (int k = 0; k < N_BULLET; k++) begin
            if (r_idx == IDX_W'(k)) begin
                w_sel_x         = w_bx[k];
                w_sel_y         = w_by[k];
                w_sel_size      = w_bsize[k];
                w_sel_col       = w_bcol[k];
                w_sel_render    = bullet_render[k];
                w_sel_onehot[k] = 1'b1;
            end
        end
    end

    aabb_overlap u_aabb (
        .i_ax    (player_pos[15:8]),
        .i_ay    (player_pos[7:0]),
        .i_asize (player_size),
        .i_bx    (w_sel_x),
        .i_by    (w_sel_y),
        .i_bsize (w_sel_size),
        .o_hit   (w_overlap)
    );

    assign w_hit = w_sel_render & w_overlap;

    always_comb begin
        w_dmg_hit  = 1'b0;
        w_heal_hit = 1'b0;
        case (w_sel_col)
            COL_WHITE:  w_dmg_hit  = w_hit;
            COL_BLUE:   w_dmg_hit  = w_hit & r_move;
            COL_ORANGE: w_dmg_hit  = w_hit & ~r_move;
            COL_GREEN:  w_heal_hit = w_hit;
            default:    ;
        endcase
    end

    assign w_invuln   = (r_inv_cnt != 16'd0);
    assign w_load_ok  = (r_state == ST_IDLE) && load_hp;
    assign w_start_ok = (r_state == ST_IDLE) && start && !load_hp && (r_hp != 8'd0);
    assign w_load_val = (hp_init > LP_MAX_HP) ? LP_MAX_HP : hp_init;
    assign w_dmg_apply = w_invuln ? 8'd0 : r_dmg_acc;

    assign w_hp_sum = $signed({2'b00, r_hp}) - $signed({2'b00, w_dmg_apply})
                    + $signed({2'b00, r_heal_acc});

    always_comb begin
        if (w_hp_sum < 10'sd0)
            w_hp_apply = 8'd0;
        else if (w_hp_sum > $signed({2'b00, LP_MAX_HP}))
            w_hp_apply = LP_MAX_HP;
        else
            w_hp_apply = w_hp_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok) w_state_next = ST_SCAN;
            ST_SCAN:  if (r_idx == LP_LAST_IDX) w_state_next = ST_APPLY;
            ST_APPLY: w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_hp         <= LP_MAX_HP;
            r_dmg_acc    <= '0;
            r_heal_acc   <= '0;
            r_dmg_total  <= '0;
            r_heal_total <= '0;
            r_hit_work   <= '0;
            r_hit_mask   <= '0;
            r_move       <= 1'b0;
            r_done       <= 1'b0;
            r_inv_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_invuln)
                r_inv_cnt <= r_inv_cnt - 16'd1;
            case (r_state)
                ST_IDLE: begin
                    if (w_load_ok) begin
                        r_hp <= w_load_val;
                    end else if (w_start_ok) begin
                        r_idx      <= '0;
                        r_dmg_acc  <= '0;
                        r_heal_acc <= '0;
                        r_hit_work <= '0;
                        r_move     <= is_move;
                    end
                end
                ST_SCAN: begin
                    if (w_dmg_hit)
                        r_dmg_acc <= sat_add8(r_dmg_acc, LP_DAMAGE);
                    if (w_heal_hit)
                        r_heal_acc <= sat_add8(r_heal_acc, LP_HEAL);
                    if (w_hit)
                        r_hit_work <= r_hit_work | w_sel_onehot;
                    r_idx <= r_idx + IDX_W'(1);
                end
                ST_APPLY: begin
                    r_hp         <= w_hp_apply;
                    r_hit_mask   <= r_hit_work;
                    r_dmg_total  <= w_dmg_apply;
                    r_heal_total <= r_heal_acc;
                    r_done       <= 1'b1;
                    // Fresh damage restarts the window, overriding the decrement.
                    if (w_dmg_apply != 8'd0 && INVULN_CYCLES > 0)
                        r_inv_cnt <= LP_INVULN;
                end
                default: ;
            endcase
        end
    end

`ifdef DAMAGE_STATS_EN
    logic [4:0]  r_dmg_hits;
    logic [15:0] r_hit_count;
    logic [16:0] w_count_sum;

    assign w_count_sum = {1'b0, r_hit_count} + 17'(r_dmg_hits);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dmg_hits  <= '0;
            r_hit_count <= '0;
        end else begin
            if (w_start_ok)
                r_dmg_hits <= '0;
            else if (r_state == ST_SCAN && w_dmg_hit)
                r_dmg_hits <= r_dmg_hits + 5'd1;
            if (clr_stats)
                r_hit_count <= '0;
            else if (r_state == ST_APPLY && !w_invuln)
                r_hit_count <= w_count_sum[16] ? 16'hFFFF : w_count_sum[15:0];
        end
    end

    assign hit_count = r_hit_count;
`endif

    assign hp         = r_hp;
    assign is_dead    = (r_hp == 8'd0);
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign invuln     = w_invuln;
    assign hit_mask   = r_hit_mask;
    assign dmg_total  = r_dmg_total;
    assign heal_total = r_heal_total;

endmodule

// File: tb/tb_bullet_damage_engine.sv
// Randomised and directed bench for bullet_damage_engine against a behavioural
// HP/invulnerability model; one line per scan transaction.
module tb_bullet_damage_engine;

    localparam int N   = 4;
    localparam int DMG = 5;
    localparam int HL  = 3;
    localparam int MHP = 20;
    localparam int INV = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          is_move = 1'b0;
    logic          load_hp = 1'b0;
    logic [7:0]    hp_init = 8'd0;
    logic [15:0]   player_pos = 16'd0;
    logic [7:0]    player_size = 8'd0;
    logic [16*N-1:0] bullet_pos = '0;
    logic [8*N-1:0]  bullet_size = '0;
    logic [3*N-1:0]  bullet_color = '0;
    logic [N-1:0]    bullet_render = '0;
    logic [7:0]    hp;
    logic          is_dead, busy, done, invuln;
    logic [N-1:0]  hit_mask;
    logic [7:0]    dmg_total, heal_total;

    bullet_damage_engine #(
        .N_BULLET(N), .DAMAGE(DMG), .HEAL(HL), .MAX_HP(MHP), .INVULN_CYCLES(INV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_move(is_move),
        .load_hp(load_hp), .hp_init(hp_init), .player_pos(player_pos),
        .player_size(player_size), .bullet_pos(bullet_pos),
        .bullet_size(bullet_size), .bullet_color(bullet_color),
        .bullet_render(bullet_render), .hp(hp), .is_dead(is_dead),
        .busy(busy), .done(done), .invuln(invuln), .hit_mask(hit_mask),
        .dmg_total(dmg_total), .heal_total(heal_total)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // Scenario state
    int px, py, ps;
    int bx[N], by[N], bs[N], bc[N], br[N];
    int m_hp = MHP;
    int m_inv_last = -1000;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int inv_exp();
        return (edge_cnt < m_inv_last + INV) ? 1 : 0;
    endfunction

    function automatic int clamp(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    task automatic drive_inputs();
        player_pos  = {8'(px), 8'(py)};
        player_size = 8'(ps);
        for (int i = 0; i < N; i++) begin
            bullet_pos[16*i +: 16]  = {8'(bx[i]), 8'(by[i])};
            bullet_size[8*i +: 8]   = 8'(bs[i]);
            bullet_color[3*i +: 3]  = 3'(bc[i]);
            bullet_render[i]        = br[i][0];
        end
    endtask

    task automatic set_bullet(input int i, input int x, input int y, input int s,
                              input int c, input int r);
        bx[i] = x; by[i] = y; bs[i] = s; bc[i] = c; br[i] = r;
    endtask

    task automatic clear_bullets();
        for (int i = 0; i < N; i++) set_bullet(i, 0, 0, 0, 0, 0);
    endtask

    // Reference: plain geometric and colour rules over all channels.
    task automatic model_scan(input int mv, output int mask, output int dmg, output int heal);
        mask = 0; dmg = 0; heal = 0;
        for (int i = 0; i < N; i++) begin
            if (br[i] != 0 && px < bx[i] + bs[i] && bx[i] < px + ps &&
                py < by[i] + bs[i] && by[i] < py + ps) begin
                mask = mask | (1 << i);
                if (bc[i] == 0 || (bc[i] == 1 && mv != 0) || (bc[i] == 2 && mv == 0))
                    dmg = (dmg + DMG > 255) ? 255 : dmg + DMG;
                else if (bc[i] == 3)
                    heal = (heal + HL > 255) ? 255 : heal + HL;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_val("idle_invuln", int'(invuln), inv_exp());
            check_val("idle_busy", int'(busy), 0);
        end
    endtask

    task automatic do_load(input int v, input bit with_start);
        hp_init = 8'(v); load_hp = 1'b1; start = with_start;
        @(negedge clk);
        load_hp = 1'b0; start = 1'b0;
        m_hp = clamp(v, 0, MHP);
        check_val("load_hp", int'(hp), m_hp);
        check_val("load_busy", int'(busy), 0);
    endtask

    task automatic run_scan(input int mv, input bit extra_start);
        int mask, dmg_raw, heal, dmg_app, s, ea, k, done_k;
        model_scan(mv, mask, dmg_raw, heal);
        drive_inputs();
        s  = edge_cnt + 1;
        ea = s + N + 1;
        dmg_app = ((ea - 1) < m_inv_last + INV) ? 0 : dmg_raw;
        m_hp = clamp(m_hp - dmg_app + heal, 0, MHP);
        if (dmg_app > 0) m_inv_last = ea;
        is_move = mv[0];
        start = 1'b1;
        @(negedge clk);
        start = extra_start;
        k = 1; done_k = 0;
        check_val("busy_after_start", int'(busy), 1);
        while (k <= N + 6 && done_k == 0) begin
            if (done) done_k = k;
            else begin
                @(negedge clk);
                k++;
                if (k == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        check_val("done_latency", done_k, N + 2);
        check_val("hp", int'(hp), m_hp);
        check_val("is_dead", int'(is_dead), (m_hp == 0) ? 1 : 0);
        check_val("hit_mask", int'(hit_mask), mask);
        check_val("dmg_total", int'(dmg_total), dmg_app);
        check_val("heal_total", int'(heal_total), heal);
        check_val("invuln", int'(invuln), inv_exp());
        $display("scan mv=%0d mask=%0h dmg=%0d heal=%0d hp=%0d inv=%0d",
                 mv, hit_mask, dmg_total, heal_total, hp, invuln);
        if (extra_start) begin
            @(negedge clk);
            check_val("single_done", int'(done), 0);
            check_val("extra_start_busy", int'(busy), 0);
        end
    endtask

    initial begin
        clear_bullets();
        px = 10; py = 10; ps = 8;
        drive_inputs();
        @(negedge clk);
        @(negedge clk);
        check_val("rst_hp", int'(hp), MHP);
        check_val("rst_dead", int'(is_dead), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);
        check_val("rst_invuln", int'(invuln), 0);
        check_val("rst_mask", int'(hit_mask), 0);
        check_val("rst_dmg", int'(dmg_total), 0);
        check_val("rst_heal", int'(heal_total), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // White hit, then watch the invulnerability window expire
        set_bullet(0, 12, 12, 4, 0, 1);
        run_scan(0, 1'b0);
        check_val("white_hp", int'(hp), 15);
        idle(10);

        // Blue: harmless when still, damaging when moving
        clear_bullets();
        set_bullet(1, 12, 12, 4, 1, 1);
        run_scan(0, 1'b0);
        run_scan(1, 1'b0);
        idle(10);

        // Green heal with clamp, then white+green during invulnerability
        do_load(19, 1'b0);
        clear_bullets();
        set_bullet(2, 11, 11, 3, 3, 1);
        run_scan(0, 1'b0);
        clear_bullets();
        set_bullet(0, 12, 12, 4, 0, 1);
        run_scan(0, 1'b0);
        set_bullet(2, 11, 11, 3, 3, 1);
        run_scan(0, 1'b0);
        idle(10);

        // Four whites kill; start while dead is ignored; load revives clamped
        do_load(15, 1'b0);
        for (int i = 0; i < N; i++) set_bullet(i, 9 + i, 9 + i, 4, 0, 1);
        run_scan(0, 1'b0);
        check_val("dead_flag", int'(is_dead), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_val("dead_start_busy", int'(busy), 0);
        idle(4);
        check_val("dead_hp_held", int'(hp), 0);
        do_load(200, 1'b0);
        idle(6);

        // Touching edge and render-off: no hits
        clear_bullets();
        set_bullet(0, 18, 10, 4, 0, 1);
        set_bullet(1, 12, 12, 4, 0, 0);
        run_scan(1, 1'b0);

        // Start and load together: load wins; start during busy ignored
        do_load(12, 1'b1);
        set_bullet(1, 12, 12, 4, 2, 1);
        run_scan(0, 1'b1);
        idle(10);

        // Reset in the middle of a scan
        do_load(7, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_hp", int'(hp), MHP);
        m_hp = MHP; m_inv_last = -1000;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("midrst_no_done", int'(done), 0);
        end

        // Randomised scans
        for (int t = 0; t < 40; t++) begin
            if (m_hp == 0 || $urandom_range(0, 7) == 0)
                do_load(int'($urandom_range(1, 255)), 1'b0);
            px = int'($urandom_range(20, 200));
            py = int'($urandom_range(20, 200));
            ps = int'($urandom_range(1, 30));
            for (int i = 0; i < N; i++)
                set_bullet(i, px - 20 + int'($urandom_range(0, 40)),
                           py - 20 + int'($urandom_range(0, 40)),
                           int'($urandom_range(0, 30)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 3) != 0));
            run_scan(int'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
            idle(int'($urandom_range(0, 10)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
